// File: rtl/alu_pkg.sv
// ============================================================================
// Module   : alu_pkg
// Purpose  : Shared state encoding, ALU opcode constants and status-byte bit
//            positions for the ALU/UART sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_A    = 3'd0,
    ST_WAIT_B    = 3'd1,
    ST_WAIT_OP   = 3'd2,
    ST_EXEC      = 3'd3,
    ST_SEND_RES  = 3'd4,
    ST_SEND_STAT = 3'd5
  } state_e;

  localparam logic [5:0] OP_ADD = 6'h20;
  localparam logic [5:0] OP_SUB = 6'h22;
  localparam logic [5:0] OP_AND = 6'h24;
  localparam logic [5:0] OP_OR  = 6'h25;
  localparam logic [5:0] OP_XOR = 6'h26;
  localparam logic [5:0] OP_NOR = 6'h27;
  localparam logic [5:0] OP_SRL = 6'h02;
  localparam logic [5:0] OP_SLL = 6'h03;

  localparam int unsigned STAT_ZERO_BIT = 0;
  localparam int unsigned STAT_OVF_BIT  = 1;

endpackage

`default_nettype wire

// File: rtl/alu_uart_sequencer.sv
// ============================================================================
// Module   : alu_uart_sequencer
// Purpose  : Collects A, B and opcode bytes from the RX stream, drives them to
//            the ALU, captures the result/flags and streams them to TX.
//            Optional macro ALU_STATUS_BYTE_EN appends a flags byte after the
//            result byte.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_uart_sequencer
  import alu_pkg::*;
#(
  parameter int NB_DATA = 8,
  parameter int NB_OP   = 6
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_valid,
  output logic [NB_DATA-1:0] o_alu_data_a,
  output logic [NB_DATA-1:0] o_alu_data_b,
  output logic [NB_OP-1:0]   o_alu_op,
  input  logic [NB_DATA-1:0] i_alu_result,
  input  logic               i_alu_overflow,
  input  logic               i_alu_zero,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_valid,
  input  logic               i_tx_ready,
  output logic               o_busy,
  output logic               o_rx_drop
);

  state_e             state_q, state_d;
  logic [NB_DATA-1:0] a_q, a_d;
  logic [NB_DATA-1:0] b_q, b_d;
  logic [NB_OP-1:0]   op_q, op_d;
  logic [NB_DATA-1:0] res_q, res_d;
  logic               ovf_q, ovf_d;
  logic               zero_q, zero_d;
  logic [NB_DATA-1:0] tx_data_q, tx_data_d;
  logic               tx_valid_q, tx_valid_d;
  logic               busy_q, busy_d;
  logic               rx_drop_q, rx_drop_d;

`ifdef ALU_STATUS_BYTE_EN
  logic [NB_DATA-1:0] stat_byte;

  always_comb begin
    stat_byte                = '0;
    stat_byte[STAT_OVF_BIT]  = ovf_q;
    stat_byte[STAT_ZERO_BIT] = zero_q;
  end
`else
  // Flags are still captured so the register set is identical in both builds.
  logic unused_flags;
  assign unused_flags = ovf_q ^ zero_q;
`endif

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    res_d      = res_q;
    ovf_d      = ovf_q;
    zero_d     = zero_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    rx_drop_d  = 1'b0;

    case (state_q)
      ST_WAIT_A: begin
        if (i_rx_valid) begin
          a_d     = i_rx_data;
          state_d = ST_WAIT_B;
        end
      end
      ST_WAIT_B: begin
        if (i_rx_valid) begin
          b_d     = i_rx_data;
          state_d = ST_WAIT_OP;
        end
      end
      ST_WAIT_OP: begin
        if (i_rx_valid) begin
          op_d    = i_rx_data[NB_OP-1:0];
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        rx_drop_d  = i_rx_valid;
        res_d      = i_alu_result;
        ovf_d      = i_alu_overflow;
        zero_d     = i_alu_zero;
        tx_data_d  = i_alu_result;
        tx_valid_d = 1'b1;
        state_d    = ST_SEND_RES;
      end
      ST_SEND_RES: begin
        rx_drop_d = i_rx_valid;
        tx_data_d = res_q;
        if (i_tx_ready) begin
`ifdef ALU_STATUS_BYTE_EN
          tx_data_d = stat_byte;
          state_d   = ST_SEND_STAT;
`else
          tx_valid_d = 1'b0;
          state_d    = ST_WAIT_A;
`endif
        end
      end
`ifdef ALU_STATUS_BYTE_EN
      ST_SEND_STAT: begin
        rx_drop_d = i_rx_valid;
        if (i_tx_ready) begin
          tx_valid_d = 1'b0;
          state_d    = ST_WAIT_A;
        end
      end
`endif
      default: begin
        tx_valid_d = 1'b0;
        state_d    = ST_WAIT_A;
      end
    endcase

    // Registered from the next state so o_busy tracks state_q exactly.
    busy_d = (state_d != ST_WAIT_A);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_WAIT_A;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      res_q      <= '0;
      ovf_q      <= 1'b0;
      zero_q     <= 1'b0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      rx_drop_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      res_q      <= res_d;
      ovf_q      <= ovf_d;
      zero_q     <= zero_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
      rx_drop_q  <= rx_drop_d;
    end
  end

  assign o_alu_data_a = a_q;
  assign o_alu_data_b = b_q;
  assign o_alu_op     = op_q;
  assign o_tx_data    = tx_data_q;
  assign o_tx_valid   = tx_valid_q;
  assign o_busy       = busy_q;
  assign o_rx_drop    = rx_drop_q;

endmodule

`default_nettype wire
